id_exe_stage_reg: RTL and testbench

//  ID->EXE pipeline register. Captures the two register-file read values, operand/control fields and

---
 rtl/id_exe_stage_reg_pkg.sv | 36 +++
 rtl/id_exe_stage_reg_sat_counter.sv | 37 +++
 rtl/id_exe_stage_reg.sv | 177 +++++++++++++++++
 tb/tb_id_exe_stage_reg.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_exe_stage_reg_pkg.sv
// Shared constants and types for the ID->EXE pipeline register.
// Holds the EXE command encodings, the NZCV bit positions and the control bundle type.
package id_exe_stage_reg_pkg;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 4;
    localparam int CMD_W   = 4;
    localparam int CNT_W   = 16;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_MOV = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_ADC = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_SBC = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_AND = 4'b0110;
    localparam logic [CMD_W-1:0] CMD_ORR = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_EOR = 4'b1000;
    localparam logic [CMD_W-1:0] CMD_MVN = 4'b1001;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef struct packed {
        logic             wb_en;
        logic             mem_r_en;
        logic             mem_w_en;
        logic             b;
        logic             s;
        logic             imm;
        logic [CMD_W-1:0] cmd;
    } id_exe_ctrl_t;

endpackage

// File: rtl/id_exe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear wins over increment; the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear first, then increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register with hold, bubble and flush.
// Optional PERF_CNT_EN adds saturating stall/bubble counters.
module id_exe_stage_reg
    import id_exe_stage_reg_pkg::*;
#(
    parameter int DATA_W  = id_exe_stage_reg_pkg::DATA_W,
    parameter int RADDR_W = id_exe_stage_reg_pkg::RADDR_W,
    parameter int CMD_W   = id_exe_stage_reg_pkg::CMD_W
`ifdef PERF_CNT_EN
    ,
    parameter int CNT_W   = id_exe_stage_reg_pkg::CNT_W
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               flush,
    input  logic               hazard,
    input  logic [DATA_W-1:0]  id_pc,
    input  logic [DATA_W-1:0]  id_val_rn,
    input  logic [DATA_W-1:0]  id_val_rm,
    input  logic [RADDR_W-1:0] id_src1,
    input  logic [RADDR_W-1:0] id_src2,
    input  logic [RADDR_W-1:0] id_dest,
    input  logic [CMD_W-1:0]   id_cmd,
    input  logic               id_wb_en,
    input  logic               id_mem_r_en,
    input  logic               id_mem_w_en,
    input  logic               id_b,
    input  logic               id_s,
    input  logic               id_imm,
    input  logic [11:0]        id_shift_op,
    input  logic [23:0]        id_imm24,
    input  logic [3:0]         id_status,
    output logic [DATA_W-1:0]  exe_pc,
    output logic [DATA_W-1:0]  exe_val_rn,
    output logic [DATA_W-1:0]  exe_val_rm,
    output logic [RADDR_W-1:0] exe_src1,
    output logic [RADDR_W-1:0] exe_src2,
    output logic [RADDR_W-1:0] exe_dest,
    output logic [CMD_W-1:0]   exe_cmd,
    output logic               exe_wb_en,
    output logic               exe_mem_r_en,
    output logic               exe_mem_w_en,
    output logic               exe_b,
    output logic               exe_s,
    output logic               exe_imm,
    output logic [11:0]        exe_shift_op,
    output logic [23:0]        exe_imm24,
    output logic [3:0]         exe_status,
    output logic               exe_valid
`ifdef PERF_CNT_EN
    ,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
`endif
);

    logic               bubble;
    id_exe_ctrl_t       ctrl_d, ctrl_q;
    logic [DATA_W-1:0]  pc_d, pc_q;
    logic [DATA_W-1:0]  rn_d, rn_q;
    logic [DATA_W-1:0]  rm_d, rm_q;
    logic [RADDR_W-1:0] src1_d, src1_q;
    logic [RADDR_W-1:0] src2_d, src2_q;
    logic [RADDR_W-1:0] dest_d, dest_q;
    logic [11:0]        shift_d, shift_q;
    logic [23:0]        imm24_d, imm24_q;
    logic [3:0]         status_d, status_q;
    logic               valid_d, valid_q;

    // Flush and hazard both turn the slot into an all-zero bubble.
    assign bubble = flush | hazard;

    // Bubble-select mux: pass ID fields through or zero every field.
    always_comb begin
        ctrl_d = '{
            wb_en:    id_wb_en,
            mem_r_en: id_mem_r_en,
            mem_w_en: id_mem_w_en,
            b:        id_b,
            s:        id_s,
            imm:      id_imm,
            cmd:      id_cmd
        };
        pc_d     = id_pc;
        rn_d     = id_val_rn;
        rm_d     = id_val_rm;
        src1_d   = id_src1;
        src2_d   = id_src2;
        dest_d   = id_dest;
        shift_d  = id_shift_op;
        imm24_d  = id_imm24;
        status_d = id_status;
        valid_d  = 1'b1;
        if (bubble) begin
            ctrl_d   = '0;
            pc_d     = '0;
            rn_d     = '0;
            rm_d     = '0;
            src1_d   = '0;
            src2_d   = '0;
            dest_d   = '0;
            shift_d  = '0;
            imm24_d  = '0;
            status_d = '0;
            valid_d  = 1'b0;
        end
    end

    // Pipeline register: freeze holds everything, otherwise capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q   <= '0;
            pc_q     <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            dest_q   <= '0;
            shift_q  <= '0;
            imm24_q  <= '0;
            status_q <= '0;
            valid_q  <= 1'b0;
        end else if (!freeze) begin
            ctrl_q   <= ctrl_d;
            pc_q     <= pc_d;
            rn_q     <= rn_d;
            rm_q     <= rm_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            dest_q   <= dest_d;
            shift_q  <= shift_d;
            imm24_q  <= imm24_d;
            status_q <= status_d;
            valid_q  <= valid_d;
        end
    end

    assign exe_pc       = pc_q;
    assign exe_val_rn   = rn_q;
    assign exe_val_rm   = rm_q;
    assign exe_src1     = src1_q;
    assign exe_src2     = src2_q;
    assign exe_dest     = dest_q;
    assign exe_cmd      = ctrl_q.cmd;
    assign exe_wb_en    = ctrl_q.wb_en;
    assign exe_mem_r_en = ctrl_q.mem_r_en;
    assign exe_mem_w_en = ctrl_q.mem_w_en;
    assign exe_b        = ctrl_q.b;
    assign exe_s        = ctrl_q.s;
    assign exe_imm      = ctrl_q.imm;
    assign exe_shift_op = shift_q;
    assign exe_imm24    = imm24_q;
    assign exe_status   = status_q;
    assign exe_valid    = valid_q;

`ifdef PERF_CNT_EN
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (freeze),
        .clr_i  (cnt_clr),
        .cnt_o  (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (!freeze && bubble),
        .clr_i  (cnt_clr),
        .cnt_o  (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Self-checking bench for id_exe_stage_reg.
// Define PERF_CNT_EN to also check the stall/bubble counters (built with CNT_W=4).
module tb_id_exe_stage_reg;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  d;
        logic [3:0]  cmd;
        logic        wb;
        logic        mr;
        logic        mw;
        logic        b;
        logic        s;
        logic        imm;
        logic [11:0] sh;
        logic [23:0] i24;
        logic [3:0]  st;
        logic        v;
    } bundle_t;

    logic clk = 1'b0;
    logic rst, freeze, flush, hazard, cnt_clr;
    bundle_t in_b, obs, exp_b;
    int total = 0;
    int bad = 0;
    int stall_e, bub_e;

    logic [31:0] exe_pc, exe_val_rn, exe_val_rm;
    logic [3:0]  exe_src1, exe_src2, exe_dest, exe_cmd, exe_status;
    logic        exe_wb_en, exe_mem_r_en, exe_mem_w_en;
    logic        exe_b, exe_s, exe_imm, exe_valid;
    logic [11:0] exe_shift_op;
    logic [23:0] exe_imm24;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    always #5 clk = ~clk;

`ifdef PERF_CNT_EN
    id_exe_stage_reg #(.CNT_W(CW)) dut (
        .cnt_clr      (cnt_clr),
        .stall_cnt    (stall_cnt),
        .bubble_cnt   (bubble_cnt),
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
    id_exe_stage_reg dut (
`endif
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .flush        (flush),
        .hazard       (hazard),
        .id_pc        (in_b.pc),
        .id_val_rn    (in_b.rn),
        .id_val_rm    (in_b.rm),
        .id_src1      (in_b.s1),
        .id_src2      (in_b.s2),
        .id_dest      (in_b.d),
        .id_cmd       (in_b.cmd),
        .id_wb_en     (in_b.wb),
        .id_mem_r_en  (in_b.mr),
        .id_mem_w_en  (in_b.mw),
        .id_b         (in_b.b),
        .id_s         (in_b.s),
        .id_imm       (in_b.imm),
        .id_shift_op  (in_b.sh),
        .id_imm24     (in_b.i24),
        .id_status    (in_b.st),
        .exe_pc       (exe_pc),
        .exe_val_rn   (exe_val_rn),
        .exe_val_rm   (exe_val_rm),
        .exe_src1     (exe_src1),
        .exe_src2     (exe_src2),
        .exe_dest     (exe_dest),
        .exe_cmd      (exe_cmd),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .exe_mem_w_en (exe_mem_w_en),
        .exe_b        (exe_b),
        .exe_s        (exe_s),
        .exe_imm      (exe_imm),
        .exe_shift_op (exe_shift_op),
        .exe_imm24    (exe_imm24),
        .exe_status   (exe_status),
        .exe_valid    (exe_valid)
    );

    assign obs = {exe_pc, exe_val_rn, exe_val_rm, exe_src1, exe_src2,
                  exe_dest, exe_cmd, exe_wb_en, exe_mem_r_en,
                  exe_mem_w_en, exe_b, exe_s, exe_imm, exe_shift_op,
                  exe_imm24, exe_status, exe_valid};

    task automatic chk(input string tag, input logic [255:0] o,
                       input logic [255:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic chk_all(input string tag);
        chk(tag, 256'(obs), 256'(exp_b));
`ifdef PERF_CNT_EN
        chk({tag, "_stall"}, 256'(stall_cnt), 256'(stall_e));
        chk({tag, "_bubble"}, 256'(bubble_cnt), 256'(bub_e));
`endif
    endtask

    // Reference behaviour of one rising edge, from the stage's rules.
    task automatic model_edge();
        if (cnt_clr) begin
            stall_e = 0;
            bub_e   = 0;
        end else begin
            if (freeze) stall_e = (stall_e < SAT) ? stall_e + 1 : SAT;
            if (!freeze && (flush || hazard))
                bub_e = (bub_e < SAT) ? bub_e + 1 : SAT;
        end
        if (!freeze) begin
            if (flush || hazard) begin
                exp_b = '0;
            end else begin
                exp_b   = in_b;
                exp_b.v = 1'b1;
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic rand_in();
        in_b     = '0;
        in_b.pc  = $urandom;
        in_b.rn  = $urandom;
        in_b.rm  = $urandom;
        in_b.s1  = 4'($urandom);
        in_b.s2  = 4'($urandom);
        in_b.d   = 4'($urandom);
        in_b.cmd = 4'($urandom);
        in_b.wb  = 1'($urandom);
        in_b.mr  = 1'($urandom);
        in_b.mw  = 1'($urandom);
        in_b.b   = 1'($urandom);
        in_b.s   = 1'($urandom);
        in_b.imm = 1'($urandom);
        in_b.sh  = 12'($urandom);
        in_b.i24 = 24'($urandom);
        in_b.st  = 4'($urandom);
    endtask

    initial begin
        rst = 1'b0; freeze = 1'b0; flush = 1'b0;
        hazard = 1'b0; cnt_clr = 1'b0;
        in_b = '1;
        in_b.v = 1'b0;
        exp_b = '0; stall_e = 0; bub_e = 0;

        // 1: async reset with all-ones inputs, no clock edge yet
        #1;
        chk_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // 2: plain load
        in_b = '0;
        in_b.rn = 32'h0000_0005;
        in_b.d = 4'd3;
        in_b.wb = 1'b1;
        in_b.cmd = 4'b0010;
        step("load");
        chk("load_rn", 256'(exe_val_rn), 256'(32'h5));
        chk("load_valid", 256'(exe_valid), 256'(1'b1));

        // 3: freeze three edges while inputs change
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_in();
            step("freeze");
        end
        chk("freeze_rn", 256'(exe_val_rn), 256'(32'h5));
`ifdef PERF_CNT_EN
        chk("freeze_stall3", 256'(stall_cnt), 256'(3));
`endif
        freeze = 1'b0;

        // 4: one hazard bubble, then reload
        rand_in();
        in_b.wb = 1'b1; in_b.mw = 1'b1;
        hazard = 1'b1;
        step("hazard");
        chk("hazard_valid", 256'(exe_valid), 256'(1'b0));
        hazard = 1'b0;
        step("reload");

        // 5: flush under freeze holds, then flush alone bubbles
        cnt_clr = 1'b1;
        step("clr");
        cnt_clr = 1'b0;
        rand_in();
        freeze = 1'b1; flush = 1'b1;
        step("frz_flush");
        freeze = 1'b0;
        step("flush");
`ifdef PERF_CNT_EN
        chk("flush_bubble1", 256'(bubble_cnt), 256'(1));
`endif
        hazard = 1'b1;
        step("flush_hazard");
        flush = 1'b0; hazard = 1'b0;
        rand_in();
        step("load2");

        // 6: stall counter saturates, clear wins during freeze
        freeze = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_in();
            step("sat");
        end
`ifdef PERF_CNT_EN
        chk("stall_sat", 256'(stall_cnt), 256'(4'hF));
`endif
        cnt_clr = 1'b1;
        step("clr_frz");
        cnt_clr = 1'b0;

        // reset asserted mid-freeze clears at once
        #2;
        rst = 1'b0;
        #1;
        exp_b = '0; stall_e = 0; bub_e = 0;
        chk_all("rst_frz");
        @(negedge clk);
        rst = 1'b1;
        freeze = 1'b0;
        rand_in();
        step("post_rst");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_in();
            freeze  = ($urandom_range(0, 4) == 0);
            flush   = ($urandom_range(0, 5) == 0);
            hazard  = ($urandom_range(0, 5) == 0);
            cnt_clr = ($urandom_range(0, 19) == 0);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
